dma_mc_ctrl: RTL and testbench
==============================

Name: dma_mc_ctrl

Overview:
Multi-channel DMA controller that extends the single-register-set DMA programming block. It provides NUM_CH independent channels, each with source, destination, length and control registers, behind the same valid/wr_en register bus. A round-robin transfer engine issues one word-beat at a time on a valid/ready transfer port, and reports per-channel completion through a W1C interrupt status register and a masked irq output.

Parameters:
ADDR_WIDTH, 32, register bus and transfer address width
DATA_WIDTH, 32, register data width; address step per beat is DATA_WIDTH/8
NUM_CH, 4, channel count, 1..8
LEN_WIDTH, 16, beat-count width of the LEN register
BASE_ADDR, 'h400, base of the register map

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
addr  input  ADDR_WIDTH  register address
wr_en  input  1  1=write, 0=read; qualified by valid
valid  input  1  register access strobe
wdata  input  DATA_WIDTH  write data
rdata  output  DATA_WIDTH  read data, registered
rvalid  output  1  one-cycle pulse, rdata valid
xfer_valid  output  1  beat request
xfer_ready  input  1  beat accepted
xfer_src  output  ADDR_WIDTH  beat source address
xfer_dst  output  ADDR_WIDTH  beat destination address
xfer_ch  output  $clog2(NUM_CH) (min 1)  channel of the beat
irq  output  1  |(INTR_STATUS & INTR_MASK)

Behaviour:
- Reset (async, active-high): all registers 0, FSM IDLE, RR pointer 0. rdata=0, rvalid=0, xfer_valid=0, xfer_src/dst/ch=0, irq=0.
- Map: BASE+0x0 INTR_STATUS (bit per channel, W1C); BASE+0x4 INTR_MASK (RW). Channel c at BASE+0x10*(c+1): +0x0 CONTROL, +0x4 SRC, +0x8 DST, +0xC LEN (LEN_WIDTH bits, upper bits read 0).
- CONTROL bits: [0] start (write-only, reads 0); [1] inc_src; [2] inc_dst; [4] abort (write-only); [31] busy (read-only).
- Write: takes effect at the clk edge where valid&wr_en.
- Read: rdata/rvalid are registered one cycle after valid&!wr_en. Unmapped addresses return 0.
- Live readback: SRC, DST and LEN return current in-flight values.
- Busy channel: writes to SRC/DST/LEN and to CONTROL bits [2:1] are ignored. Only abort is honoured.
- Start with LEN!=0: sets busy next edge. Start with LEN==0: no beats; INTR_STATUS[c] is set on that edge. Start while busy is ignored.
- Engine FSM:
  - IDLE: if any channel busy, grant the next busy channel at or after the RR pointer and load xfer_*. Go to ISSUE.
  - ISSUE: xfer_valid=1. xfer_src/dst/ch are held stable until xfer_ready. On handshake:
    - SRC += DATA_WIDTH/8 if inc_src; DST += DATA_WIDTH/8 if inc_dst (modulo 2^ADDR_WIDTH, wrap allowed).
    - LEN -= 1; if LEN reaches 0, clear busy and set INTR_STATUS[c].
    - RR pointer = c+1 mod NUM_CH. Return to IDLE.
  - Sustained throughput is one beat per 2 cycles. Channels interleave beat-by-beat.
- Abort:
  - If the channel is not currently granted: clears busy at that edge. No interrupt; LEN keeps the remaining count.
  - If the channel is granted in ISSUE: abort is held pending, the outstanding beat completes normally, then busy clears. If that beat was the last, completion wins and the interrupt is set.
- Same-edge set and W1C clear of an INTR_STATUS bit: set wins.
- A register write and a completion update to the same register on the same edge: engine update wins; the write is dropped.
- irq is combinational from registers, with no glitch-producing inputs.

Decomposition:
- Package dma_mc_pkg holds:
  - register offsets (INTR_STATUS_OFS, INTR_MASK_OFS, CH_STRIDE, CTRL/SRC/DST/LEN_OFS);
  - CONTROL bit-index constants;
  - FSM state enum {IDLE, ISSUE};
  - per-channel register struct typedef.
- One sub-module, dma_rr_arbiter: NUM_CH request vector plus pointer in, one-hot/index grant and any_req out; purely combinational.

Test Plan:
- Ch0: SRC=0x1000, DST=0x2000, LEN=3, CONTROL=0x7, xfer_ready=1 -> beats (0x1000,0x2000), (0x1004,0x2004), (0x1008,0x2008) on ch0. INTR_STATUS reads 0x1; irq=1 only after INTR_MASK=0x1; write 0x1 to INTR_STATUS -> irq=0.
- Ch0 and ch1 both LEN=2, started the same cycle -> beat order ch0, ch1, ch0, ch1. INTR_STATUS ends 0x3.
- xfer_ready held low 5 cycles mid-transfer -> xfer_valid and xfer_src/dst/ch are stable throughout; the beat count is unchanged.
- Start with LEN=0 on ch2 (CONTROL at 0x430) -> zero beats; INTR_STATUS[2]=1 on the next read.
- Ch1 LEN=10, abort after 4 beats while ready=0 -> the 5th beat completes, busy=0, LEN reads 5, INTR_STATUS[1]=0.
- Read at 0x500 -> rvalid one cycle later with rdata=0. Reset asserted mid-transfer -> xfer_valid drops immediately; all registers read 0.

Source files
------------

// File: rtl/dma_mc_pkg.sv
// rtl/dma_mc_pkg.sv - register map, control bits, FSM states and channel state type for the multi-channel DMA
package dma_mc_pkg;

    localparam int INTR_STATUS_OFS = 'h0;
    localparam int INTR_MASK_OFS   = 'h4;
    localparam int CH_STRIDE       = 'h10;

    localparam int CTRL_OFS = 'h0;
    localparam int SRC_OFS  = 'h4;
    localparam int DST_OFS  = 'h8;
    localparam int LEN_OFS  = 'hC;

    localparam int CTRL_START_BIT   = 0;
    localparam int CTRL_INC_SRC_BIT = 1;
    localparam int CTRL_INC_DST_BIT = 2;
    localparam int CTRL_ABORT_BIT   = 4;
    localparam int CTRL_BUSY_BIT    = 31;

    typedef enum logic {
        IDLE,
        ISSUE
    } dma_state_t;

    // abort_pend marks an abort that arrived while this channel's beat was on the port
    typedef struct packed {
        logic busy;
        logic inc_src;
        logic inc_dst;
        logic abort_pend;
    } ch_ctrl_t;

endpackage

// File: rtl/dma_rr_arbiter.sv
// rtl/dma_rr_arbiter.sv - combinational round-robin pick of the first requester at or after a pointer
module dma_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              any_req
);

    // walk the channels starting at ptr, wrapping, and take the first one requesting
    always_comb begin
        int          j;
        logic [CH_W-1:0] jj;
        logic        found;
        j       = 0;
        jj      = '0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            j = int'(ptr) + i;
            if (j >= NUM_CH) j = j - NUM_CH;
            jj = CH_W'(j);
            if (!found && req[jj]) begin
                found   = 1'b1;
                gnt_idx = jj;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/dma_mc_ctrl.sv
// rtl/dma_mc_ctrl.sv - multi-channel DMA register block with round-robin single-beat transfer engine
module dma_mc_ctrl
    import dma_mc_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_CH     = 4,
    parameter int                    LEN_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h400
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  wr_en,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  xfer_valid,
    input  logic                  xfer_ready,
    output logic [ADDR_WIDTH-1:0] xfer_src,
    output logic [ADDR_WIDTH-1:0] xfer_dst,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] xfer_ch,
    output logic                  irq
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

    ch_ctrl_t              ctl    [NUM_CH];
    logic [ADDR_WIDTH-1:0] src_q  [NUM_CH];
    logic [ADDR_WIDTH-1:0] dst_q  [NUM_CH];
    logic [LEN_WIDTH-1:0]  len_q  [NUM_CH];
    logic [NUM_CH-1:0]     intr_status;
    logic [NUM_CH-1:0]     intr_mask;
    dma_state_t            state;
    logic [CH_W-1:0]       rr_ptr;

    logic [ADDR_WIDTH-1:0] off;
    int unsigned           blk;
    logic [3:0]            fld;
    logic                  ch_hit;
    logic [CH_W-1:0]       ch_idx;
    logic                  glb_status_hit;
    logic                  glb_mask_hit;
    logic                  wr_strobe;
    logic                  rd_strobe;
    logic [NUM_CH-1:0]     ch_wr;
    logic [NUM_CH-1:0]     abort_vec;
    logic [NUM_CH-1:0]     req_vec;
    logic [CH_W-1:0]       gnt_idx;
    logic                  any_req;
    logic [DATA_WIDTH-1:0] rd_val;

    assign wr_strobe      = valid & wr_en;
    assign rd_strobe      = valid & ~wr_en;
    assign off            = addr - BASE_ADDR;
    assign blk            = 32'(off / ADDR_WIDTH'(CH_STRIDE));
    assign fld            = off[3:0];
    assign ch_hit         = (blk >= 1) && (blk <= NUM_CH);
    assign ch_idx         = CH_W'(blk - 1);
    assign glb_status_hit = (off == ADDR_WIDTH'(INTR_STATUS_OFS));
    assign glb_mask_hit   = (off == ADDR_WIDTH'(INTR_MASK_OFS));

    // per-channel write strobes; an abort to a busy channel also removes it from arbitration this cycle
    always_comb begin
        ch_wr     = '0;
        abort_vec = '0;
        req_vec   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_wr[c]     = wr_strobe && ch_hit && (ch_idx == CH_W'(c));
            abort_vec[c] = ch_wr[c] && (fld == 4'(CTRL_OFS)) && wdata[CTRL_ABORT_BIT] && ctl[c].busy;
            req_vec[c]   = ctl[c].busy && !abort_vec[c];
        end
    end

    dma_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req     (req_vec),
        .ptr     (rr_ptr),
        .gnt_idx (gnt_idx),
        .any_req (any_req)
    );

    // read mux over the live register state; anything unmapped or misaligned reads 0
    always_comb begin
        rd_val = '0;
        if (glb_status_hit) begin
            rd_val = DATA_WIDTH'(intr_status);
        end else if (glb_mask_hit) begin
            rd_val = DATA_WIDTH'(intr_mask);
        end else if (ch_hit) begin
            if (fld == 4'(CTRL_OFS)) begin
                rd_val[CTRL_BUSY_BIT]    = ctl[ch_idx].busy;
                rd_val[CTRL_INC_SRC_BIT] = ctl[ch_idx].inc_src;
                rd_val[CTRL_INC_DST_BIT] = ctl[ch_idx].inc_dst;
            end else if (fld == 4'(SRC_OFS)) begin
                rd_val = DATA_WIDTH'(src_q[ch_idx]);
            end else if (fld == 4'(DST_OFS)) begin
                rd_val = DATA_WIDTH'(dst_q[ch_idx]);
            end else if (fld == 4'(LEN_OFS)) begin
                rd_val = DATA_WIDTH'(len_q[ch_idx]);
            end
        end
    end

    // register writes first, engine updates after so that the engine wins on a same-edge collision
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ctl[c]   <= '0;
                src_q[c] <= '0;
                dst_q[c] <= '0;
                len_q[c] <= '0;
            end
            intr_status <= '0;
            intr_mask   <= '0;
            state       <= IDLE;
            rr_ptr      <= '0;
            xfer_valid  <= 1'b0;
            xfer_src    <= '0;
            xfer_dst    <= '0;
            xfer_ch     <= '0;
            rdata       <= '0;
            rvalid      <= 1'b0;
        end else begin
            rvalid <= rd_strobe;
            if (rd_strobe) rdata <= rd_val;

            if (wr_strobe && glb_status_hit) intr_status <= intr_status & ~wdata[NUM_CH-1:0];
            if (wr_strobe && glb_mask_hit)   intr_mask   <= wdata[NUM_CH-1:0];

            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_wr[c]) begin
                    if (fld == 4'(CTRL_OFS)) begin
                        if (ctl[c].busy) begin
                            if (abort_vec[c]) begin
                                if (state == ISSUE && xfer_ch == CH_W'(c)) ctl[c].abort_pend <= 1'b1;
                                else ctl[c].busy <= 1'b0;
                            end
                        end else begin
                            ctl[c].inc_src <= wdata[CTRL_INC_SRC_BIT];
                            ctl[c].inc_dst <= wdata[CTRL_INC_DST_BIT];
                            if (wdata[CTRL_START_BIT] && !wdata[CTRL_ABORT_BIT]) begin
                                if (len_q[c] != '0) ctl[c].busy <= 1'b1;
                                else intr_status[c] <= 1'b1;
                            end
                        end
                    end else if (!ctl[c].busy) begin
                        if (fld == 4'(SRC_OFS)) src_q[c] <= ADDR_WIDTH'(wdata);
                        if (fld == 4'(DST_OFS)) dst_q[c] <= ADDR_WIDTH'(wdata);
                        if (fld == 4'(LEN_OFS)) len_q[c] <= wdata[LEN_WIDTH-1:0];
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (any_req) begin
                        xfer_ch    <= gnt_idx;
                        xfer_src   <= src_q[gnt_idx];
                        xfer_dst   <= dst_q[gnt_idx];
                        xfer_valid <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (xfer_ready) begin
                        xfer_valid <= 1'b0;
                        state      <= IDLE;
                        if (ctl[xfer_ch].inc_src) src_q[xfer_ch] <= src_q[xfer_ch] + STEP;
                        if (ctl[xfer_ch].inc_dst) dst_q[xfer_ch] <= dst_q[xfer_ch] + STEP;
                        len_q[xfer_ch] <= len_q[xfer_ch] - LEN_WIDTH'(1);
                        if (len_q[xfer_ch] == LEN_WIDTH'(1)) begin
                            ctl[xfer_ch].busy    <= 1'b0;
                            intr_status[xfer_ch] <= 1'b1;
                        end else if (ctl[xfer_ch].abort_pend || abort_vec[xfer_ch]) begin
                            ctl[xfer_ch].busy <= 1'b0;
                        end
                        ctl[xfer_ch].abort_pend <= 1'b0;
                        if (xfer_ch == CH_W'(NUM_CH - 1)) rr_ptr <= '0;
                        else rr_ptr <= xfer_ch + CH_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign irq = |(intr_status & intr_mask);

endmodule

// File: tb/tb_dma_mc_ctrl.sv
// tb/tb_dma_mc_ctrl.sv - self-checking bench for dma_mc_ctrl against a per-channel beat-list model
module tb_dma_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic        wr_en = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        xfer_valid;
    logic        xfer_ready = 1'b0;
    logic [31:0] xfer_src;
    logic [31:0] xfer_dst;
    logic [1:0]  xfer_ch;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;
    int ready_mode = 0;

    typedef struct {
        int          ch;
        logic [31:0] src;
        logic [31:0] dst;
    } beat_t;
    beat_t beats[$];

    dma_mc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .wr_en      (wr_en),
        .valid      (valid),
        .wdata      (wdata),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .xfer_valid (xfer_valid),
        .xfer_ready (xfer_ready),
        .xfer_src   (xfer_src),
        .xfer_dst   (xfer_dst),
        .xfer_ch    (xfer_ch),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       xfer_ready = 1'b1;
            1:       xfer_ready = 1'($urandom_range(0, 1));
            default: xfer_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!reset && xfer_valid && xfer_ready)
            beats.push_back('{int'(xfer_ch), xfer_src, xfer_dst});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ch_base(input int c);
        return 32'h400 + 32'h10 * (c + 1);
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr_en = 1'b1; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0; wr_en = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        @(negedge clk);
        addr = a; wr_en = 1'b0; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        check({tag, "_rvalid"}, {31'b0, rvalid}, 32'd1);
        check(tag, rdata, exp);
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k;
        k = 0;
        while (beats.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (!xfer_valid && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'b0, xfer_valid}, 32'd1);
    endtask

    logic [31:0] m_src [4];
    logic [31:0] m_dst [4];
    int          m_len [4];
    bit          m_en  [4];
    bit          m_is  [4];
    bit          m_id  [4];

    initial begin
        int total;
        int idx;
        logic [31:0] exp_st;
        logic [31:0] e_src, e_dst;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_xfer_valid", {31'b0, xfer_valid}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_rvalid", {31'b0, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rd_check("rst_status", 32'h400, 32'd0);
        rd_check("rst_ch0_len", 32'h41C, 32'd0);

        // single channel, three incrementing beats, then interrupt masking and W1C
        ready_mode = 0;
        wr(32'h414, 32'h1000);
        wr(32'h418, 32'h2000);
        wr(32'h41C, 32'd3);
        beats.delete();
        wr(32'h410, 32'h7);
        wait_beats(3, 100);
        repeat (4) @(negedge clk);
        check("t1_nbeats", beats.size(), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < beats.size()) begin
                check("t1_src", beats[k].src, 32'h1000 + 32'(4 * k));
                check("t1_dst", beats[k].dst, 32'h2000 + 32'(4 * k));
                check("t1_ch", beats[k].ch, 32'd0);
            end
        end
        rd_check("t1_status", 32'h400, 32'h1);
        check("t1_irq_masked", {31'b0, irq}, 32'd0);
        wr(32'h404, 32'h1);
        check("t1_irq_on", {31'b0, irq}, 32'd1);
        wr(32'h400, 32'h1);
        check("t1_irq_cleared", {31'b0, irq}, 32'd0);
        rd_check("t1_src_live", 32'h414, 32'h100C);
        rd_check("t1_len_done", 32'h41C, 32'd0);
        rd_check("t1_ctrl", 32'h410, 32'h6);

        // two channels interleave beat by beat
        ready_mode = 2;
        wr(32'h414, 32'h3000); wr(32'h418, 32'h4000); wr(32'h41C, 32'd2);
        wr(32'h424, 32'h5000); wr(32'h428, 32'h6000); wr(32'h42C, 32'd2);
        beats.delete();
        wr(32'h410, 32'h7);
        wr(32'h420, 32'h7);
        ready_mode = 0;
        wait_beats(4, 100);
        repeat (4) @(negedge clk);
        check("t2_nbeats", beats.size(), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < beats.size()) begin
                check("t2_order", beats[k].ch, 32'(k % 2));
                check("t2_src", beats[k].src, ((k % 2) == 0 ? 32'h3000 : 32'h5000) + 32'(4 * (k / 2)));
            end
        end
        rd_check("t2_status", 32'h400, 32'h3);
        wr(32'h400, 32'hF);

        // back-pressure: port outputs hold while ready is low
        wr(32'h414, 32'h7000); wr(32'h418, 32'h8000); wr(32'h41C, 32'd4);
        beats.delete();
        wr(32'h410, 32'h7);
        wait_beats(1, 50);
        ready_mode = 2;
        wait_valid("t3_valid_wait", 20);
        for (int k = 0; k < 5; k++) begin
            check("t3_hold_valid", {31'b0, xfer_valid}, 32'd1);
            check("t3_hold_src", xfer_src, 32'h7004);
            check("t3_hold_dst", xfer_dst, 32'h8004);
            check("t3_hold_ch", {30'b0, xfer_ch}, 32'd0);
            @(negedge clk);
        end
        check("t3_count_held", beats.size(), 32'd1);
        ready_mode = 0;
        wait_beats(4, 100);
        repeat (4) @(negedge clk);
        check("t3_nbeats", beats.size(), 32'd4);
        if (beats.size() == 4) check("t3_last_src", beats[3].src, 32'h700C);
        wr(32'h400, 32'hF);

        // zero-length start completes immediately with no beats
        wr(32'h43C, 32'd0);
        beats.delete();
        wr(32'h430, 32'h1);
        repeat (5) @(negedge clk);
        check("t4_nbeats", beats.size(), 32'd0);
        rd_check("t4_status", 32'h400, 32'h4);
        wr(32'h400, 32'hF);

        // abort while the channel's beat is stalled on the port
        wr(32'h424, 32'h9000); wr(32'h428, 32'hA000); wr(32'h42C, 32'd10);
        ready_mode = 0;
        beats.delete();
        wr(32'h420, 32'h7);
        wait_beats(4, 100);
        ready_mode = 2;
        wait_valid("t5_valid_wait", 20);
        wr(32'h420, 32'h10);
        check("t5_valid_after_abort", {31'b0, xfer_valid}, 32'd1);
        ready_mode = 0;
        wait_beats(5, 50);
        repeat (6) @(negedge clk);
        check("t5_nbeats", beats.size(), 32'd5);
        rd_check("t5_len", 32'h42C, 32'd5);
        rd_check("t5_ctrl", 32'h420, 32'h6);
        rd_check("t5_status", 32'h400, 32'h0);

        // unmapped read
        rd_check("t6_unmapped", 32'h500, 32'h0);

        // randomized channel mixes against the beat-list model
        for (int it = 0; it < 6; it++) begin
            wr(32'h400, 32'hF);
            ready_mode = 1;
            total = 0;
            exp_st = '0;
            for (int c = 0; c < 4; c++) begin
                m_en[c]  = 1'($urandom_range(0, 1));
                m_len[c] = $urandom_range(0, 5);
                m_src[c] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
                m_dst[c] = $urandom & 32'hFFFF_FFFC;
                m_is[c]  = 1'($urandom_range(0, 1));
                m_id[c]  = 1'($urandom_range(0, 1));
                if (m_en[c]) begin
                    wr(ch_base(c) + 32'h4, m_src[c]);
                    wr(ch_base(c) + 32'h8, m_dst[c]);
                    wr(ch_base(c) + 32'hC, 32'(m_len[c]));
                    total += m_len[c];
                    exp_st[c] = 1'b1;
                end
            end
            beats.delete();
            for (int c = 0; c < 4; c++)
                if (m_en[c]) wr(ch_base(c), {29'b0, m_id[c], m_is[c], 1'b1});
            wait_beats(total, 600);
            repeat (8) @(negedge clk);
            check("rnd_nbeats", beats.size(), 32'(total));
            for (int c = 0; c < 4; c++) begin
                if (m_en[c]) begin
                    idx = 0;
                    foreach (beats[i]) begin
                        if (beats[i].ch == c) begin
                            e_src = m_src[c] + (m_is[c] ? 32'(4 * idx) : 32'd0);
                            e_dst = m_dst[c] + (m_id[c] ? 32'(4 * idx) : 32'd0);
                            check("rnd_src", beats[i].src, e_src);
                            check("rnd_dst", beats[i].dst, e_dst);
                            idx++;
                        end
                    end
                    check("rnd_ch_beats", 32'(idx), 32'(m_len[c]));
                    rd_check("rnd_src_final", ch_base(c) + 32'h4,
                             m_src[c] + (m_is[c] ? 32'(4 * m_len[c]) : 32'd0));
                    rd_check("rnd_len_final", ch_base(c) + 32'hC, 32'd0);
                end
            end
            rd_check("rnd_status", 32'h400, exp_st);
        end

        // asynchronous reset in the middle of a stalled beat
        ready_mode = 2;
        wr(32'h444, 32'hB000); wr(32'h448, 32'hC000); wr(32'h44C, 32'd5);
        wr(32'h440, 32'h7);
        wait_valid("t7_valid_wait", 20);
        #2;
        reset = 1'b1;
        #1;
        check("t7_valid_drop", {31'b0, xfer_valid}, 32'd0);
        check("t7_irq", {31'b0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ready_mode = 0;
        rd_check("t7_mask", 32'h404, 32'd0);
        rd_check("t7_len", 32'h44C, 32'd0);
        rd_check("t7_src", 32'h444, 32'd0);
        rd_check("t7_ctrl", 32'h440, 32'd0);
        repeat (4) @(negedge clk);
        check("t7_idle", {31'b0, xfer_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
